// File: rtl/dpi_stream_sequencer.sv
// Feeds one packet at a time to a bank of category matchers, restoring per-stream matcher state.
// Optional per-stream category mask table is enabled by defining DPI_SEQ_CAT_MASK_EN.
`timescale 1ns/1ps
module dpi_stream_sequencer #(
    parameter int NUM_CAT = 8,
    parameter int EOP_DLY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pkt_vld,
    output logic               pkt_rdy,
    input  logic               pkt_sop,
    input  logic               pkt_eop,
    input  logic [7:0]         pkt_data,
    input  logic [5:0]         pkt_stream_id,
    input  logic               stream_clr,
    input  logic [5:0]         stream_clr_id,
`ifdef DPI_SEQ_CAT_MASK_EN
    input  logic               cfg_wr,
    input  logic [5:0]         cfg_stream_id,
    input  logic [NUM_CAT-1:0] cfg_mask,
`endif
    output logic               load_state,
    output logic               new_stream_id,
    output logic [5:0]         stream_id,
    output logic [7:0]         char_in,
    output logic               char_in_vld,
    output logic               eop,
    output logic [NUM_CAT-1:0] enable,
    output logic               busy,
    output logic [15:0]        pkt_count
);

    localparam int CNT_W = (EOP_DLY > 0) ? $clog2(EOP_DLY + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        DATA,
        DRAIN,
        EOP
    } state_t;

    state_t          state;
    logic            run;
    logic [63:0]     known;
    logic [CNT_W-1:0] drain_cnt;
    logic            sop_take;
    logic            byte_take;

    // run holds ready low until the first clock after reset release
    assign pkt_rdy   = run && (((state == IDLE) && !pkt_sop) || (state == DATA));
    assign sop_take  = (state == IDLE) && pkt_vld && pkt_sop;
    assign byte_take = (state == DATA) && pkt_vld && pkt_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            run           <= 1'b0;
            known         <= '0;
            drain_cnt     <= '0;
            pkt_count     <= '0;
            load_state    <= 1'b0;
            new_stream_id <= 1'b0;
            stream_id     <= '0;
            char_in       <= '0;
            char_in_vld   <= 1'b0;
            eop           <= 1'b0;
            busy          <= 1'b0;
        end else begin
            run           <= 1'b1;
            load_state    <= 1'b0;
            new_stream_id <= 1'b0;
            char_in_vld   <= 1'b0;
            eop           <= 1'b0;
            if (stream_clr) begin
                known[stream_clr_id] <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (sop_take) begin
                        state         <= LOAD;
                        stream_id     <= pkt_stream_id;
                        load_state    <= 1'b1;
                        new_stream_id <= ~known[pkt_stream_id] |
                                         (stream_clr && (stream_clr_id == pkt_stream_id));
                        busy          <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    state <= DATA;
                end
                DATA: begin
                    if (byte_take) begin
                        char_in     <= pkt_data;
                        char_in_vld <= 1'b1;
                        if (pkt_eop) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    // the first DRAIN cycle carries the last char_in_vld
                    if (drain_cnt == CNT_W'(EOP_DLY)) begin
                        state <= EOP;
                        eop   <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + CNT_W'(1);
                    end
                end
                EOP: begin
                    known[stream_id] <= 1'b1;
                    pkt_count        <= pkt_count + 16'd1;
                    busy             <= 1'b0;
                    state            <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DPI_SEQ_CAT_MASK_EN
    logic [NUM_CAT-1:0] mask_tbl [64];
    logic [NUM_CAT-1:0] enable_q;

    // a write landing on the SOP cycle is forwarded so the packet sees the newest mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                mask_tbl[i] <= '1;
            end
            enable_q <= '1;
        end else begin
            if (cfg_wr) begin
                mask_tbl[cfg_stream_id] <= cfg_mask;
            end
            if (sop_take) begin
                enable_q <= (cfg_wr && (cfg_stream_id == pkt_stream_id)) ?
                            cfg_mask : mask_tbl[pkt_stream_id];
            end
        end
    end

    assign enable = enable_q;
`else
    assign enable = '1;
`endif

endmodule
